// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin front end for the single-ported DataMemory. It serves two
// requesters: port 0 is the CPU load/store path and port 1 is DMA/debug.
// Each access is range- and alignment-checked, then issued as a single
// registered MemRead/MemWrite cycle. The requester gets a one-cycle ack or
// err pulse back, and the read data is held after the pulse.
//
// Ports
//   clk, reset              : system clock, asynchronous active-high reset
//   rN_req/we/addr/wdata    : requester N command. Held until ack/err.
//   rN_ack/err/rdata        : requester N completion, error and read data
//   mem_addr/read/write/
//   mem_wdata/mem_rdata     : DataMemory interface. rdata changes at negedge.
module dmem_arbiter #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [31:0]   r0_wdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [31:0]   r1_wdata,
    output logic          r0_ack,
    output logic          r0_err,
    output logic [31:0]   r0_rdata,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [31:0]   r1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // One extra bit so that 4*DEPTH is representable even when it equals 2**AW.
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(4 * DEPTH);

    state_t        r_state;
    logic          r_last_grant;
    logic          r_port;
    logic          r_we;

    state_t        w_state_nx;
    logic          w_last_grant_nx;
    logic          w_port_nx;
    logic          w_we_nx;
    logic          w_r0_ack_nx, w_r1_ack_nx;
    logic          w_r0_err_nx, w_r1_err_nx;
    logic [31:0]   w_r0_rdata_nx, w_r1_rdata_nx;
    logic [AW-1:0] w_mem_addr_nx;
    logic          w_mem_read_nx, w_mem_write_nx;
    logic [31:0]   w_mem_wdata_nx;

    logic          w_pick;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic          w_legal;

    // Winner: the only requester, or the one not granted last time when both ask.
    assign w_pick      = (r0_req && r1_req) ? ~r_last_grant : r1_req;
    assign w_sel_we    = w_pick ? r1_we    : r0_we;
    assign w_sel_addr  = w_pick ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_pick ? r1_wdata : r0_wdata;
    assign w_legal     = (w_sel_addr[1:0] == 2'b00) && ({1'b0, w_sel_addr} < ADDR_LIMIT);

    always_comb begin
        w_state_nx      = r_state;
        w_last_grant_nx = r_last_grant;
        w_port_nx       = r_port;
        w_we_nx         = r_we;
        w_r0_ack_nx     = 1'b0;
        w_r1_ack_nx     = 1'b0;
        w_r0_err_nx     = 1'b0;
        w_r1_err_nx     = 1'b0;
        w_r0_rdata_nx   = r0_rdata;
        w_r1_rdata_nx   = r1_rdata;
        w_mem_addr_nx   = mem_addr;
        w_mem_read_nx   = 1'b0;
        w_mem_write_nx  = 1'b0;
        w_mem_wdata_nx  = mem_wdata;

        unique case (r_state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    w_last_grant_nx = w_pick;
                    w_port_nx       = w_pick;
                    w_we_nx         = w_sel_we;
                    if (w_legal) begin
                        w_mem_addr_nx  = w_sel_addr;
                        w_mem_read_nx  = ~w_sel_we;
                        w_mem_write_nx = w_sel_we;
                        w_mem_wdata_nx = w_sel_wdata;
                        w_state_nx     = ACCESS;
                    end else begin
                        // Error responses skip ACCESS, so err is raised here.
                        w_r0_err_nx = ~w_pick;
                        w_r1_err_nx = w_pick;
                        w_state_nx  = RESP;
                    end
                end
            end
            ACCESS: begin
                // mem_rdata was loaded by DataMemory at the negedge inside this cycle.
                w_r0_ack_nx = ~r_port;
                w_r1_ack_nx = r_port;
                if (!r_we) begin
                    if (r_port) w_r1_rdata_nx = mem_rdata;
                    else        w_r0_rdata_nx = mem_rdata;
                end
                w_state_nx = RESP;
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_err       <= 1'b0;
            r1_err       <= 1'b0;
            r0_rdata     <= '0;
            r1_rdata     <= '0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_last_grant <= w_last_grant_nx;
            r_port       <= w_port_nx;
            r_we         <= w_we_nx;
            r0_ack       <= w_r0_ack_nx;
            r1_ack       <= w_r1_ack_nx;
            r0_err       <= w_r0_err_nx;
            r1_err       <= w_r1_err_nx;
            r0_rdata     <= w_r0_rdata_nx;
            r1_rdata     <= w_r1_rdata_nx;
            mem_addr     <= w_mem_addr_nx;
            mem_read     <= w_mem_read_nx;
            mem_write    <= w_mem_write_nx;
            mem_wdata    <= w_mem_wdata_nx;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Drives both requesters with directed and random commands. A negedge
// DataMemory is attached to the memory port. The per-cycle arbiter outputs
// are compared against a transaction-level round-robin model.
module tb_dmem_arbiter;
    localparam int DEPTH = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [31:0]   r0_wdata = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [31:0]   r1_wdata = '0;
    logic          r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0]   r0_rdata, r1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_read, mem_write;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Attached DataMemory: acts on the falling edge while a strobe is high.
    logic [31:0] tb_mem [DEPTH] = '{default: '0};
    always @(negedge clk) begin
        if (mem_write && mem_addr < 32'(4 * DEPTH)) tb_mem[int'(mem_addr >> 2)] <= mem_wdata;
        if (mem_read  && mem_addr < 32'(4 * DEPTH)) mem_rdata <= tb_mem[int'(mem_addr >> 2)];
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH] = '{default: '0};
    bit          lg = 1'b1;
    logic [31:0] exp_rd [2] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack0"},  r0_ack, 0);    chk({tag, "_err0"},  r0_err, 0);
        chk({tag, "_ack1"},  r1_ack, 0);    chk({tag, "_err1"},  r1_err, 0);
        chk({tag, "_rd0"},   r0_rdata, 0);  chk({tag, "_rd1"},   r1_rdata, 0);
        chk({tag, "_maddr"}, mem_addr, 0);  chk({tag, "_mwd"},   mem_wdata, 0);
        chk({tag, "_mrd"},   mem_read, 0);  chk({tag, "_mwr"},   mem_write, 0);
    endtask

    // One round: the enabled ports raise req together and hold it until served.
    // The model decides the service order and the cycle of every strobe and pulse.
    task automatic run_round(input bit e0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                             input bit e1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                             input int gap);
        bit          en [2];
        bit          w  [2];
        bit          ok [2];
        logic [31:0] ad [2];
        logic [31:0] dd [2];
        int          start [2];
        int          resp  [2];
        int          order [$];
        int          s;
        int          last_n;
        bit          x_rd, x_wr;
        int          sp;

        en[0] = e0; w[0] = we0; ad[0] = a0; dd[0] = d0;
        en[1] = e1; w[1] = we1; ad[1] = a1; dd[1] = d1;
        start = '{-1, -1};
        resp  = '{-1, -1};
        ok    = '{1'b0, 1'b0};

        if (e0 && e1) begin
            order.push_back(lg ? 0 : 1);
            order.push_back(lg ? 1 : 0);
        end else if (e0) order.push_back(0);
        else if (e1) order.push_back(1);

        s = 1;
        foreach (order[k]) begin
            int p = order[k];
            ok[p]    = legal(ad[p]);
            start[p] = s;
            resp[p]  = ok[p] ? s + 1 : s;
            s        = s + (ok[p] ? 3 : 2);
            lg       = p[0];
            if (ok[p]) begin
                if (w[p]) ref_mem[int'(ad[p] >> 2)] = dd[p];
                else      exp_rd[p] = ref_mem[int'(ad[p] >> 2)];
            end
        end
        last_n = s - 1 + gap;

        r0_we = we0; r0_addr = a0; r0_wdata = d0; r0_req = e0;
        r1_we = we1; r1_addr = a1; r1_wdata = d1; r1_req = e1;

        for (int n = 1; n <= last_n; n++) begin
            @(posedge clk); #1;
            chk("r0_ack", r0_ack, 32'(en[0] && ok[0]  && n == resp[0]));
            chk("r0_err", r0_err, 32'(en[0] && !ok[0] && n == resp[0]));
            chk("r1_ack", r1_ack, 32'(en[1] && ok[1]  && n == resp[1]));
            chk("r1_err", r1_err, 32'(en[1] && !ok[1] && n == resp[1]));
            x_rd = 1'b0; x_wr = 1'b0; sp = -1;
            for (int p = 0; p < 2; p++) begin
                if (en[p] && ok[p] && n == start[p]) begin
                    sp = p;
                    if (w[p]) x_wr = 1'b1; else x_rd = 1'b1;
                end
            end
            chk("mem_read", mem_read, 32'(x_rd));
            chk("mem_write", mem_write, 32'(x_wr));
            if (sp >= 0) begin
                chk("mem_addr", mem_addr, ad[sp]);
                if (x_wr) chk("mem_wdata", mem_wdata, dd[sp]);
            end
            if (en[0] && n == resp[0]) begin
                chk("r0_rdata", r0_rdata, exp_rd[0]);
                r0_req = 1'b0;
            end
            if (en[1] && n == resp[1]) begin
                chk("r1_rdata", r1_rdata, exp_rd[1]);
                r1_req = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r == 7) return (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 8) return 32'(4 * DEPTH) + (32'($urandom_range(0, 15)) << 2);
        else             return 32'h8000_0000 | 32'($urandom);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic write then read-back on port 0
        run_round(1, 1, 32'h08, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        run_round(1, 0, 32'h08, 0,            0, 0, 0, 0, 1);

        // Reset during ACCESS of a write, before the memory's negedge
        r0_we = 1'b1; r0_addr = 32'h10; r0_wdata = 32'hA5A5A5A5; r0_req = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_wr", mem_write, 1);
        reset = 1'b1;
        #1;
        chk_all_zero("midrst");
        r0_req = 1'b0;
        @(negedge clk); #1;
        chk("rst_no_wr", mem_write, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        lg = 1'b1;
        exp_rd = '{default: '0};

        // Both read simultaneously after reset: port 0 first, then port 1.
        // Port 0 reads the aborted-write location and must see the old value.
        run_round(1, 0, 32'h10, 0, 1, 0, 32'h08, 0, 0);
        run_round(1, 0, 32'h08, 0, 1, 0, 32'h10, 0, 0);
        run_round(1, 0, 32'h00, 0, 1, 0, 32'h04, 0, 0);

        // Errors on port 1: misaligned read, out-of-range write
        run_round(0, 0, 0, 0, 1, 0, 32'h06, 0,            0);
        run_round(0, 0, 0, 0, 1, 1, 32'h80, 32'hCAFEF00D, 0);

        // Last word written by port 1 and read back by port 0
        run_round(0, 0, 0,     0, 1, 1, 32'h7C, 32'h12345678, 0);
        run_round(1, 0, 32'h7C, 0, 0, 0, 0,     0,            0);

        for (int i = 0; i < 200; i++) begin
            run_round(1'($urandom), 1'($urandom), rand_addr(), $urandom,
                      1'($urandom), 1'($urandom), rand_addr(), $urandom,
                      int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < DEPTH; i++) chk("mem_word", tb_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester controller in front of the single-ported DataMemory. It arbitrates round-robin between port 0 (CPU load/store) and port 1 (DMA/debug loader), checks addresses, and sequences each access as one registered MemRead/MemWrite cycle. It captures the negedge-registered ReadData and returns it with a one-cycle ack/err pulse to the granted requester.

Parameters:
DEPTH, 32, number of 32-bit words in the attached DataMemory; valid byte addresses are 0..4*DEPTH-1.
AW, 32, requester and memory address width in bits.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
r0_req, r1_req  input  1  access request; held high until ack or err is seen.
r0_we, r1_we  input  1  1 = write, 0 = read; stable while req is high.
r0_addr, r1_addr  input  AW  byte address; stable while req is high.
r0_wdata, r1_wdata  input  32  write data; stable while req is high.
r0_ack, r1_ack  output  1  one-cycle completion pulse.
r0_err, r1_err  output  1  one-cycle error pulse, mutually exclusive with ack.
r0_rdata, r1_rdata  output  32  read data; valid while ack is high, held afterwards.
mem_addr  output  AW  to DataMemory addr.
mem_read  output  1  to DataMemory MemRead.
mem_write  output  1  to DataMemory MemWrite.
mem_wdata  output  32  to DataMemory WriteData.
mem_rdata  input  32  from DataMemory ReadData; updated at negedge.

Behaviour:
- All outputs are registered. Reset value is 0 for every output; state = IDLE; last_grant = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no req, stay in IDLE. Otherwise pick the winner:
  - only one req high: that port wins;
  - both high: the port != last_grant wins.
  - Then set last_grant <= winner and latch the winner's we/addr/wdata.
- Address check on the winner:
  - Legal when addr[1:0] == 0 and addr < 4*DEPTH. Drive mem_addr <= addr, mem_read <= ~we, mem_write <= we, mem_wdata <= wdata, and go to ACCESS.
  - Illegal: no memory strobe, go to RESP with err flagged.
- ACCESS (exactly 1 cycle): strobes stay high across the clk-low phase, so DataMemory acts at that negedge.
  - At the next posedge: clear mem_read and mem_write, go to RESP, and assert winner ack.
  - For a read, also load winner rdata <= mem_rdata.
  - For a write, winner rdata keeps its previous value.
  - mem_addr and mem_wdata hold their last values; they are don't-care while strobes are low.
- RESP (exactly 1 cycle): winner ack or err is high for this one cycle. At the next posedge clear ack/err and go to IDLE.
- Latency from the posedge where IDLE samples req to the ack-high cycle:
  - legal access: 1 cycle after ACCESS, i.e. ack high during the 2nd cycle after sampling;
  - illegal access: err high during the 1st cycle after sampling.
- Requester rule: sample ack/err at a posedge, then drop req before the next posedge. RESP->IDLE adds one cycle, so a dropped req is never re-served.
  - Throughput: 3 cycles per legal access, 2 per error.
- The loser keeps req high and is served on the next IDLE. Round-robin guarantees it is served within one access of the competitor.
- Only one access is ever in flight. Strobes are never high outside ACCESS, and mem_read and mem_write are never both high.
- Reset asserted mid-operation: all outputs and state clear immediately without waiting for a clock.
  - If reset rises before the ACCESS negedge, the write is suppressed. If it rises after, the write has already landed.
  - No ack is produced for the aborted access.
- The arbiter never presents an address >= 4*DEPTH, so DataMemory's index is always in range.

Test Plan:
- Reset, then r0 write addr 0x08 data 0xDEADBEEF -> mem_write high exactly 1 cycle with mem_addr 0x08; r0_ack pulses 2 cycles after sampling; r1_ack stays 0.
- r0 read addr 0x08 after that write -> mem_read high 1 cycle; r0_rdata = 0xDEADBEEF while r0_ack is high; memory unchanged.
- r0 and r1 both request reads in the same cycle after reset -> r0 is served first, r1 next. With both held continuously, grants alternate 0,1,0,1 at a 3-cycle period.
- r1 read addr 0x06 (misaligned) and r1 write addr 0x80 (DEPTH=32) -> r1_err pulses 1 cycle after sampling; mem_read and mem_write never assert; memory unchanged.
- r1 write addr 0x7C data 0x12345678 (last word), then r0 read 0x7C -> r0_rdata = 0x12345678.
- Assert reset during ACCESS of a write to 0x10 before the negedge -> all outputs 0 immediately; no ack; a later read of 0x10 returns the old value 0.
